// File: rtl/gpio_pad_ctrl.sv
// 16-bit GPIO controller on the PicoRV32 iomem bus: output/enable registers,
// two-flop input synchronizer and per-pin edge interrupt with W1C status.
module gpio_pad_ctrl #(
    parameter logic [31:0] BASE_ADR = 32'h0300_0000,
    parameter int          NPINS    = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oeb,
    output logic             irq
);

    localparam logic [5:0] OFF_DATA       = 6'h00;
    localparam logic [5:0] OFF_OE         = 6'h01;
    localparam logic [5:0] OFF_IRQ_EN     = 6'h02;
    localparam logic [5:0] OFF_IRQ_EDGE   = 6'h03;
    localparam logic [5:0] OFF_IRQ_STATUS = 6'h04;

    // Bus handshake: iomem_valid is held by the master until iomem_ready is
    // seen; an access is accepted on the edge where it is selected and
    // iomem_ready is low, and iomem_ready/iomem_rdata are valid for exactly
    // the following cycle.
    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [NPINS-1:0] r_out;
    logic [NPINS-1:0] r_oe;
    logic [NPINS-1:0] r_en;
    logic [NPINS-1:0] r_edge;
    logic [NPINS-1:0] r_status;
    logic [NPINS-1:0] r_sync1;
    logic [NPINS-1:0] r_sync2;
    logic [NPINS-1:0] r_prev;

    logic             w_sel;
    logic             w_accept;
    logic             w_we;
    logic [5:0]       w_off;
    logic [NPINS-1:0] w_wmask;
    logic [NPINS-1:0] w_wval;
    logic [NPINS-1:0] w_rise;
    logic [NPINS-1:0] w_fall;
    logic [NPINS-1:0] w_hit;
    logic [NPINS-1:0] w_w1c;
    logic [31:0]      w_rmux;
    logic             w_unused;

    assign w_sel    = iomem_valid && (iomem_addr[31:8] == BASE_ADR[31:8]);
    assign w_accept = w_sel && !r_ready;
    assign w_we     = w_accept && (iomem_wstrb[1:0] != 2'b00);
    assign w_off    = iomem_addr[7:2];
    assign w_wmask  = {{8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_wval   = iomem_wdata[NPINS-1:0] & w_wmask;
    assign w_unused = ^{iomem_addr[1:0], iomem_wstrb[3:2], iomem_wdata[31:16]};

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;
    assign w_hit  = r_en & ((r_edge & w_fall) | (~r_edge & w_rise));
    assign w_w1c  = (w_we && (w_off == OFF_IRQ_STATUS)) ? w_wval : '0;

    always_comb begin
        w_rmux = 32'b0;
        case (w_off)
            OFF_DATA:       w_rmux = {{(32-NPINS){1'b0}}, r_sync2};
            OFF_OE:         w_rmux = {{(32-NPINS){1'b0}}, r_oe};
            OFF_IRQ_EN:     w_rmux = {{(32-NPINS){1'b0}}, r_en};
            OFF_IRQ_EDGE:   w_rmux = {{(32-NPINS){1'b0}}, r_edge};
            OFF_IRQ_STATUS: w_rmux = {{(32-NPINS){1'b0}}, r_status};
            default:        w_rmux = 32'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= 32'b0;
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_accept ? w_rmux : 32'b0;
        end
    end

    // Partial byte-lane writes keep the unselected lane's old contents.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out  <= '0;
            r_oe   <= '0;
            r_en   <= '0;
            r_edge <= '0;
        end else if (w_we) begin
            case (w_off)
                OFF_DATA:     r_out  <= (r_out  & ~w_wmask) | w_wval;
                OFF_OE:       r_oe   <= (r_oe   & ~w_wmask) | w_wval;
                OFF_IRQ_EN:   r_en   <= (r_en   & ~w_wmask) | w_wval;
                OFF_IRQ_EDGE: r_edge <= (r_edge & ~w_wmask) | w_wval;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_status <= '0;
        end else begin
            r_sync1  <= gpio_in;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            // A new hit wins over a clear of the same bit in the same cycle.
            r_status <= (r_status & ~w_w1c) | w_hit;
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oeb    = ~r_oe;
    assign irq         = |r_status;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomized bench for gpio_pad_ctrl with a pad-history reference model.
module tb_gpio_pad_ctrl;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'b0;
    logic [31:0] iomem_addr = 32'b0;
    logic [31:0] iomem_wdata = 32'b0;
    logic [31:0] iomem_rdata;
    logic [15:0] gpio_in = 16'b0;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oeb;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // model: registers as firmware sees them, plus the pad values sampled on
    // the last three edges (a pad value becomes visible two samples later)
    logic [15:0] m_out = '0, m_oe = '0, m_en = '0, m_edge = '0;
    logic [15:0] m_status, m_w1c = '0, m_hit;
    logic [15:0] hist [0:2];

    logic [31:0] rd, ex;
    int          lat;
    logic        ra;

    gpio_pad_ctrl dut (
        .clk(clk), .resetn(resetn),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_hit = '0;
        for (int i = 0; i < 16; i++) begin
            if (m_en[i]) begin
                if (m_edge[i]) m_hit[i] = hist[2][i] && !hist[1][i];
                else           m_hit[i] = !hist[2][i] && hist[1][i];
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist[0]  <= '0;
            hist[1]  <= '0;
            hist[2]  <= '0;
            m_status <= '0;
        end else begin
            m_status <= (m_status & ~m_w1c) | m_hit;
            hist[0]  <= gpio_in;
            hist[1]  <= hist[0];
            hist[2]  <= hist[1];
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:8] != BASE[31:8]) return 32'b0;
        case (a[7:2])
            6'h00:   return {16'b0, hist[1]};
            6'h01:   return {16'b0, m_oe};
            6'h02:   return {16'b0, m_en};
            6'h03:   return {16'b0, m_edge};
            6'h04:   return {16'b0, m_status};
            default: return 32'b0;
        endcase
    endfunction

    // Called #1 after an edge; the access is accepted on the next edge.
    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                            output logic [31:0] r, output logic [31:0] e,
                            output int l, output logic rdy_after);
        logic [15:0] mask;
        logic        hit_win;
        mask    = {{8{s[1]}}, {8{s[0]}}};
        hit_win = (a[31:8] == BASE[31:8]);
        iomem_addr  = a;
        iomem_wstrb = s;
        iomem_wdata = d;
        iomem_valid = 1'b1;
        e = model_read(a);
        if (hit_win && a[7:2] == 6'h04) m_w1c = d[15:0] & mask;
        l = 0;
        do begin
            @(posedge clk); #1;
            l++;
        end while (!iomem_ready && l < 8);
        r = iomem_rdata;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'b0;
        m_w1c = '0;
        if (hit_win && l == 1) begin
            case (a[7:2])
                6'h00: m_out  = (m_out  & ~mask) | (d[15:0] & mask);
                6'h01: m_oe   = (m_oe   & ~mask) | (d[15:0] & mask);
                6'h02: m_en   = (m_en   & ~mask) | (d[15:0] & mask);
                6'h03: m_edge = (m_edge & ~mask) | (d[15:0] & mask);
                default: ;
            endcase
        end
        @(posedge clk); #1;
        rdy_after = iomem_ready;
    endtask

    task automatic wait_clk(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic model_clear();
        m_out = '0; m_oe = '0; m_en = '0; m_edge = '0; m_w1c = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        gpio_in = 16'($urandom);
        model_clear();
        wait_clk(3);
        n_vec++; if (gpio_oeb !== 16'hFFFF) begin n_err++; $display("FAIL reset_oeb got %h want FFFF", gpio_oeb); end
        n_vec++; if (gpio_out !== 16'h0000) begin n_err++; $display("FAIL reset_out got %h want 0000", gpio_out); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
        n_vec++; if (iomem_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", iomem_ready); end
        n_vec++; if (iomem_rdata !== 32'b0) begin n_err++; $display("FAIL reset_rdata got %h want 0", iomem_rdata); end
        resetn = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_oe_data();
        bus_xfer(BASE + 32'h04, 4'hF, 32'h0000_FF00, rd, ex, lat, ra);
        n_vec++; if (lat !== 1 || ra !== 1'b0) begin n_err++; $display("FAIL oe_ack lat=%0d ready_after=%b want 1/0", lat, ra); end
        bus_xfer(BASE + 32'h00, 4'hF, 32'h0000_A000, rd, ex, lat, ra);
        n_vec++; if (lat !== 1 || ra !== 1'b0) begin n_err++; $display("FAIL data_ack lat=%0d ready_after=%b want 1/0", lat, ra); end
        n_vec++; if (gpio_out[15:8] !== 8'hA0) begin n_err++; $display("FAIL data_out got %h want A0", gpio_out[15:8]); end
        n_vec++; if (gpio_oeb !== 16'h00FF) begin n_err++; $display("FAIL oe_oeb got %h want 00FF", gpio_oeb); end
        for (int i = 0; i < 6; i++) begin
            bus_xfer(BASE + 32'h04, 4'hF, $urandom, rd, ex, lat, ra);
            bus_xfer(BASE + 32'h00, 4'h3, $urandom, rd, ex, lat, ra);
            bus_xfer(BASE + 32'h04, 4'h0, 32'b0, rd, ex, lat, ra);
            n_vec++; if (rd !== ex) begin n_err++; $display("FAIL oe_readback got %h want %h", rd, ex); end
            n_vec++; if (gpio_out !== m_out || gpio_oeb !== ~m_oe) begin
                n_err++; $display("FAIL rand_out got %h/%h want %h/%h", gpio_out, gpio_oeb, m_out, ~m_oe);
            end
        end
    endtask

    task automatic test_input_sync();
        gpio_in = 16'h0000;
        wait_clk(4);
        gpio_in = 16'h00F0;
        wait_clk(1);
        bus_xfer(BASE, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd[7:0] !== 8'h00) begin n_err++; $display("FAIL sync_early got %h want 00", rd[7:0]); end
        gpio_in = 16'h0000;
        wait_clk(4);
        gpio_in = 16'h00F0;
        wait_clk(2);
        bus_xfer(BASE, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd[7:0] !== 8'hF0) begin n_err++; $display("FAIL sync_late got %h want F0", rd[7:0]); end
        for (int i = 0; i < 10; i++) begin
            gpio_in = 16'($urandom);
            wait_clk($urandom_range(0, 3));
            bus_xfer(BASE, 4'h0, 32'b0, rd, ex, lat, ra);
            n_vec++; if (rd !== ex) begin n_err++; $display("FAIL sync_rand got %h want %h", rd, ex); end
        end
    endtask

    task automatic test_byte_strobes();
        bus_xfer(BASE, 4'hF, 32'h0, rd, ex, lat, ra);
        bus_xfer(BASE, 4'b0010, 32'h0000_ABCD, rd, ex, lat, ra);
        n_vec++; if (gpio_out !== 16'hAB00) begin n_err++; $display("FAIL strobe_hi got %h want AB00", gpio_out); end
        bus_xfer(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF, rd, ex, lat, ra);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL unmapped_ack lat=%0d want 1", lat); end
        n_vec++; if (gpio_out !== 16'hAB00 || gpio_oeb !== ~m_oe) begin
            n_err++; $display("FAIL unmapped_wr got %h/%h want AB00/%h", gpio_out, gpio_oeb, ~m_oe);
        end
        bus_xfer(BASE + 32'h20, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd !== 32'b0) begin n_err++; $display("FAIL unmapped_rd got %h want 0", rd); end
        bus_xfer(32'h0400_0000, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (lat < 8) begin n_err++; $display("FAIL out_of_window acked after %0d want none", lat); end
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = BASE + {24'b0, 3'(($urandom_range(0, 5))), 2'b00, 2'($urandom)};
            bus_xfer(a, 4'($urandom), $urandom, rd, ex, lat, ra);
            bus_xfer(a, 4'h0, 32'b0, rd, ex, lat, ra);
            n_vec++; if (rd !== ex) begin n_err++; $display("FAIL strobe_rd @%h got %h want %h", a, rd, ex); end
            n_vec++; if (gpio_out !== m_out || gpio_oeb !== ~m_oe) begin
                n_err++; $display("FAIL strobe_out got %h/%h want %h/%h", gpio_out, gpio_oeb, m_out, ~m_oe);
            end
        end
    endtask

    task automatic test_irq();
        bus_xfer(BASE + 32'h08, 4'hF, 32'h0, rd, ex, lat, ra);
        gpio_in = 16'h0002;
        wait_clk(4);
        bus_xfer(BASE + 32'h08, 4'hF, 32'h0003, rd, ex, lat, ra);
        bus_xfer(BASE + 32'h0C, 4'hF, 32'h0002, rd, ex, lat, ra);
        bus_xfer(BASE + 32'h10, 4'hF, 32'hFFFF, rd, ex, lat, ra);
        gpio_in = 16'h0003;
        wait_clk(2);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", irq); end
        wait_clk(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise got %b want 1", irq); end
        gpio_in = 16'h0001;
        wait_clk(3);
        bus_xfer(BASE + 32'h10, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd !== 32'h0003) begin n_err++; $display("FAIL irq_fall got %h want 0003", rd); end
        gpio_in = 16'h0005;
        wait_clk(4);
        gpio_in = 16'h0001;
        wait_clk(4);
        bus_xfer(BASE + 32'h10, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd !== 32'h0003) begin n_err++; $display("FAIL irq_pin2 got %h want 0003", rd); end
    endtask

    task automatic test_w1c_race();
        gpio_in = 16'h0000;
        wait_clk(4);
        gpio_in = 16'h0001;
        wait_clk(2);
        bus_xfer(BASE + 32'h10, 4'hF, 32'h0001, rd, ex, lat, ra);
        bus_xfer(BASE + 32'h10, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd !== 32'h0003) begin n_err++; $display("FAIL w1c_race got %h want 0003", rd); end
        bus_xfer(BASE + 32'h10, 4'hF, 32'h0003, rd, ex, lat, ra);
        bus_xfer(BASE + 32'h10, 4'h0, 32'b0, rd, ex, lat, ra);
        n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL w1c_clear got %h want 0", rd); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b want 0", irq); end
    endtask

    task automatic test_random_irq();
        for (int r = 0; r < 6; r++) begin
            bus_xfer(BASE + 32'h08, 4'hF, $urandom, rd, ex, lat, ra);
            bus_xfer(BASE + 32'h0C, 4'hF, $urandom, rd, ex, lat, ra);
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(0, 2) == 0) gpio_in = gpio_in ^ 16'($urandom);
                wait_clk(1);
                n_vec++; if (irq !== (|m_status)) begin n_err++; $display("FAIL rand_irq got %b want %b", irq, |m_status); end
            end
            bus_xfer(BASE + 32'h10, 4'h0, 32'b0, rd, ex, lat, ra);
            n_vec++; if (rd !== ex) begin n_err++; $display("FAIL rand_status got %h want %h", rd, ex); end
            bus_xfer(BASE + 32'h10, 4'($urandom), $urandom, rd, ex, lat, ra);
        end
    endtask

    task automatic test_reset_mid();
        bus_xfer(BASE, 4'hF, 32'h1234, rd, ex, lat, ra);
        iomem_addr = BASE; iomem_wdata = 32'hFFFF; iomem_wstrb = 4'hF; iomem_valid = 1'b1;
        #2 resetn = 1'b0;
        model_clear();
        wait_clk(2);
        n_vec++; if (gpio_out !== 16'h0 || iomem_ready !== 1'b0 || iomem_rdata !== 32'b0) begin
            n_err++; $display("FAIL mid_reset got out=%h rdy=%b rd=%h want 0/0/0", gpio_out, iomem_ready, iomem_rdata);
        end
        iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        resetn = 1'b1;
        wait_clk(3);
        n_vec++; if (gpio_out !== 16'h0 || gpio_oeb !== 16'hFFFF) begin
            n_err++; $display("FAIL mid_reset_after got %h/%h want 0000/FFFF", gpio_out, gpio_oeb);
        end
    endtask

    initial begin
        test_reset();
        test_oe_data();
        test_input_sync();
        test_byte_strobes();
        test_irq();
        test_w1c_race();
        test_random_irq();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
